// File: rtl/rmii_tx_fsm.sv
// rtl/rmii_tx_fsm.sv - RMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap
// One dibit per 50 MHz clock; all wire outputs are registered from the next-state decode.
module rmii_tx_fsm #(
  parameter int IFG_DIBITS = 48,
  parameter int MIN_LEN    = 60,
  parameter bit APPEND_FCS = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rmii_txen,
  output logic [1:0] rmii_txd
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [31:0] POLY      = 32'hEDB88320;
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_DIBITS - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  sh, sh_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic [10:0] byte_cnt, byte_cnt_n, byte_inc;
  logic        last, last_n;
  logic        txen_n, done_n, err_n;
  logic [1:0]  txd_n;
  logic        short_frame, payload_end, underrun;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The CRC folds in whatever dibit is currently on the wire during DATA/PAD.
  assign crc_upd     = crc_dibit(crc, rmii_txd);
  assign byte_inc    = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  // byte_cnt already includes the byte on the wire; this reads "byte_cnt < MIN_LEN".
  assign short_frame = ({1'b0, byte_cnt} + 12'd1) <= MIN_LEN_W;
  assign s_ready     = ((state == PRE) && (cnt == 16'd31)) ||
                       ((state == DATA) && (cnt[1:0] == 2'd3) && !last);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 16'd1;
    sh_n        = sh >> 2;
    crc_n       = crc;
    byte_cnt_n  = byte_cnt;
    last_n      = last;
    txen_n      = 1'b0;
    txd_n       = 2'b00;
    done_n      = 1'b0;
    err_n       = 1'b0;
    payload_end = 1'b0;
    underrun    = 1'b0;

    case (state)
      IDLE: begin
        cnt_n      = 16'd0;
        byte_cnt_n = 11'd0;
        if (s_valid) begin
          state_n = PRE;
          crc_n   = 32'hFFFF_FFFF;
          txen_n  = 1'b1;
          txd_n   = 2'b01;
        end
      end
      PRE: begin
        if (cnt != 16'd31) begin
          txen_n = 1'b1;
          txd_n  = (cnt == 16'd30) ? 2'b11 : 2'b01;
        end else if (s_valid) begin
          state_n    = DATA;
          cnt_n      = 16'd0;
          sh_n       = {2'b00, s_data[7:2]};
          last_n     = s_last;
          byte_cnt_n = byte_inc;
          txen_n     = 1'b1;
          txd_n      = s_data[1:0];
        end else begin
          underrun = 1'b1;
        end
      end
      DATA: begin
        crc_n = crc_upd;
        if (cnt[1:0] != 2'd3) begin
          txen_n = 1'b1;
          txd_n  = sh[1:0];
        end else if (last) begin
          if (short_frame) begin
            state_n    = PAD;
            cnt_n      = 16'd0;
            byte_cnt_n = byte_inc;
            txen_n     = 1'b1;
          end else begin
            payload_end = 1'b1;
          end
        end else if (s_valid) begin
          cnt_n      = 16'd0;
          sh_n       = {2'b00, s_data[7:2]};
          last_n     = s_last;
          byte_cnt_n = byte_inc;
          txen_n     = 1'b1;
          txd_n      = s_data[1:0];
        end else begin
          underrun = 1'b1;
        end
      end
      PAD: begin
        crc_n = crc_upd;
        if (cnt[1:0] != 2'd3) begin
          txen_n = 1'b1;
        end else if (short_frame) begin
          cnt_n      = 16'd0;
          byte_cnt_n = byte_inc;
          txen_n     = 1'b1;
        end else begin
          payload_end = 1'b1;
        end
      end
      FCS: begin
        // crc holds final_crc >> 2k while FCS dibit k is on the wire.
        crc_n = crc >> 2;
        if (cnt != 16'd15) begin
          txen_n = 1'b1;
          txd_n  = ~crc[3:2];
        end else begin
          state_n = IFG;
          cnt_n   = 16'd0;
          done_n  = 1'b1;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          state_n = IDLE;
          cnt_n   = 16'd0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (payload_end) begin
      cnt_n = 16'd0;
      if (APPEND_FCS) begin
        state_n = FCS;
        crc_n   = crc_upd;
        txen_n  = 1'b1;
        txd_n   = ~crc_upd[1:0];
      end else begin
        state_n = IFG;
        done_n  = 1'b1;
      end
    end

    if (underrun) begin
      state_n    = IFG;
      cnt_n      = 16'd0;
      byte_cnt_n = 11'd0;
      crc_n      = 32'd0;
      txen_n     = 1'b0;
      err_n      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      sh        <= 8'd0;
      crc       <= 32'hFFFF_FFFF;
      byte_cnt  <= 11'd0;
      last      <= 1'b0;
      rmii_txen <= 1'b0;
      rmii_txd  <= 2'b00;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      crc       <= crc_n;
      byte_cnt  <= byte_cnt_n;
      last      <= last_n;
      rmii_txen <= txen_n;
      rmii_txd  <= txd_n;
      busy      <= (state_n != IDLE);
      tx_done   <= done_n;
      tx_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_rmii_tx_fsm.sv
// tb/tb_rmii_tx_fsm.sv - directed self-checking bench for rmii_tx_fsm
// Two instances: default parameters, and MIN_LEN=0 for the unpadded CRC known-answer frame.
module tb_rmii_tx_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, s_valid, s_last, sel, abort;
  logic [7:0] s_data;

  logic       sv_a, rdy_a, busy_a, done_a, err_a, txen_a;
  logic       sv_b, rdy_b, busy_b, done_b, err_b, txen_b;
  logic [1:0] txd_a, txd_b;
  logic       rdy, mon_busy, mon_done, mon_err, mon_txen;
  logic [1:0] mon_txd;

  assign sv_a     = s_valid & ~sel;
  assign sv_b     = s_valid & sel;
  assign rdy      = sel ? rdy_b  : rdy_a;
  assign mon_busy = sel ? busy_b : busy_a;
  assign mon_done = sel ? done_b : done_a;
  assign mon_err  = sel ? err_b  : err_a;
  assign mon_txen = sel ? txen_b : txen_a;
  assign mon_txd  = sel ? txd_b  : txd_a;

  rmii_tx_fsm dut (
    .clk(clk), .rstn(rstn), .s_valid(sv_a), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_a), .busy(busy_a), .tx_done(done_a), .tx_err(err_a),
    .rmii_txen(txen_a), .rmii_txd(txd_a)
  );

  rmii_tx_fsm #(.MIN_LEN(0)) dut_nopad (
    .clk(clk), .rstn(rstn), .s_valid(sv_b), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_b), .busy(busy_b), .tx_done(done_b), .tx_err(err_b),
    .rmii_txen(txen_b), .rmii_txd(txd_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] cap[$];
  int         rise_q[$];
  int         fall_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         err_cyc = -1;
  logic       prev_txen = 1'b0;

  always @(negedge clk) begin
    if (mon_txen) cap.push_back(mon_txd);
    if (mon_txen && !prev_txen) rise_q.push_back(cyc);
    if (!mon_txen && prev_txen) fall_q.push_back(cyc);
    prev_txen = mon_txen;
    if (mon_done) done_cnt++;
    if (mon_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  logic [7:0] tx_bytes[$];
  logic       tx_last_q[$];
  logic [7:0] exp_bytes[$];

  function automatic void add_frame(input int n, input int first, input int step);
    for (int i = 0; i < n; i++) begin
      tx_bytes.push_back(8'(first + i * step));
      tx_last_q.push_back(i == n - 1);
    end
  endfunction

  function automatic void set_exp(input int n, input int first, input int step, input int padto);
    exp_bytes.delete();
    for (int i = 0; i < n; i++) exp_bytes.push_back(8'(first + i * step));
    while (exp_bytes.size() < padto) exp_bytes.push_back(8'h00);
  endfunction

  function automatic logic [7:0] wire_byte(input int off);
    if (off < 0 || off + 3 >= cap.size()) return 8'hxx;
    return {cap[off+3], cap[off+2], cap[off+1], cap[off]};
  endfunction

  function automatic int pre_bad(input int off);
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (off + i >= cap.size()) bad++;
      else if (cap[off+i] != ((i == 31) ? 2'b11 : 2'b01)) bad++;
    end
    return bad;
  endfunction

  function automatic int data_bad(input int off);
    int bad = 0;
    for (int k = 0; k < exp_bytes.size(); k++)
      if (wire_byte(off + 32 + 4 * k) !== exp_bytes[k]) bad++;
    return bad;
  endfunction

  function automatic logic [31:0] wire_fcs(input int off, input int n);
    int b;
    b = off + 32 + 4 * n;
    return {wire_byte(b + 12), wire_byte(b + 8), wire_byte(b + 4), wire_byte(b)};
  endfunction

  // Byte-at-a-time reflected CRC-32 over exp_bytes, final inversion applied.
  function automatic logic [31:0] model_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < exp_bytes.size(); k++) begin
      c = c ^ {24'd0, exp_bytes[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input int drop_at);
    int idx, guard;
    idx = 0;
    guard = 0;
    s_valid = 1'b1;
    s_data  = tx_bytes[0];
    s_last  = tx_last_q[0];
    while (idx < tx_bytes.size() && !abort && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (rdy && s_valid) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx == drop_at || idx >= tx_bytes.size() || abort) begin
          s_valid = 1'b0;
        end else begin
          s_data = tx_bytes[idx];
          s_last = tx_last_q[idx];
        end
        if (idx == drop_at) break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_fall(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (fall_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; sel = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (mon_txen !== 1'b0) begin fails++; $display("FAIL reset_txen got %0b want 0", mon_txen); end
    tests++; if (mon_txd !== 2'b00) begin fails++; $display("FAIL reset_txd got %b want 00", mon_txd); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %0b want 0", rdy); end
    tests++; if (mon_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", mon_busy); end
    tests++; if (mon_done !== 1'b0 || mon_err !== 1'b0) begin
      fails++; $display("FAIL reset_pulses got done=%0b err=%0b want 0 0", mon_done, mon_err);
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame64();
    int cb, rb, fb, db, eb, st, r, f;
    bit ok;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(64, 8'h00, 1);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size(); db = done_cnt; eb = err_cnt; st = cyc;
    fork
      drive(-1);
      wait_fall(fb + 1, ok);
    join
    set_exp(64, 8'h00, 1, 60);
    r = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL f64_timeout got no txen fall want one"); end
    tests++; if (r - st !== 1) begin fails++; $display("FAIL f64_start_latency got %0d want 1", r - st); end
    tests++; if (f - r !== 304) begin fails++; $display("FAIL f64_txen_len got %0d want 304", f - r); end
    tests++; if (pre_bad(cb) !== 0) begin fails++; $display("FAIL f64_preamble got %0d bad dibits want 0", pre_bad(cb)); end
    tests++; if (data_bad(cb) !== 0) begin fails++; $display("FAIL f64_data got %0d bad bytes want 0", data_bad(cb)); end
    tests++; if (wire_fcs(cb, 64) !== model_fcs()) begin
      fails++; $display("FAIL f64_fcs got %08h want %08h", wire_fcs(cb, 64), model_fcs());
    end
    tests++; if (done_cnt - db !== 1 || err_cnt - eb !== 0) begin
      fails++; $display("FAIL f64_pulses got done=%0d err=%0d want 1 0", done_cnt - db, err_cnt - eb);
    end
    repeat (60) @(posedge clk);
  endtask

  task automatic test_padding();
    int cb, rb, fb, db, r, f;
    bit ok;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(1, 8'hAB, 0);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size(); db = done_cnt;
    fork
      drive(-1);
      wait_fall(fb + 1, ok);
    join
    set_exp(1, 8'hAB, 0, 60);
    r = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL pad_timeout got no txen fall want one"); end
    tests++; if (f - r !== 288) begin fails++; $display("FAIL pad_txen_len got %0d want 288", f - r); end
    tests++; if (data_bad(cb) !== 0) begin fails++; $display("FAIL pad_data got %0d bad bytes want 0", data_bad(cb)); end
    tests++; if (wire_fcs(cb, 60) !== model_fcs()) begin
      fails++; $display("FAIL pad_fcs got %08h want %08h", wire_fcs(cb, 60), model_fcs());
    end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL pad_done got %0d want 1", done_cnt - db); end
    repeat (60) @(posedge clk);
  endtask

  task automatic test_fcs_kat();
    int cb, rb, fb, r, f;
    bit ok;
    @(posedge clk); #1;
    sel = 1'b1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(9, 8'h31, 1);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size();
    fork
      drive(-1);
      wait_fall(fb + 1, ok);
    join
    set_exp(9, 8'h31, 1, 0);
    r = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL kat_timeout got no txen fall want one"); end
    tests++; if (f - r !== 84) begin fails++; $display("FAIL kat_txen_len got %0d want 84", f - r); end
    tests++; if (data_bad(cb) !== 0) begin fails++; $display("FAIL kat_data got %0d bad bytes want 0", data_bad(cb)); end
    tests++; if (wire_byte(cb + 68) !== 8'h26) begin fails++; $display("FAIL kat_fcs0 got %02h want 26", wire_byte(cb + 68)); end
    tests++; if (wire_byte(cb + 72) !== 8'h39) begin fails++; $display("FAIL kat_fcs1 got %02h want 39", wire_byte(cb + 72)); end
    tests++; if (wire_byte(cb + 76) !== 8'hF4) begin fails++; $display("FAIL kat_fcs2 got %02h want f4", wire_byte(cb + 76)); end
    tests++; if (wire_byte(cb + 80) !== 8'hCB) begin fails++; $display("FAIL kat_fcs3 got %02h want cb", wire_byte(cb + 80)); end
    repeat (60) @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic test_underrun();
    int cb, rb, fb, db, eb, r, f, r2, cb2;
    bit ok, ok2;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(20, 8'h10, 1);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size(); db = done_cnt; eb = err_cnt;
    fork
      drive(10);
      wait_fall(fb + 1, ok);
    join
    set_exp(10, 8'h10, 1, 0);
    r = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL urun_timeout got no txen fall want one"); end
    tests++; if (f - r !== 72) begin fails++; $display("FAIL urun_txen_len got %0d want 72", f - r); end
    tests++; if (data_bad(cb) !== 0) begin fails++; $display("FAIL urun_data got %0d bad bytes want 0", data_bad(cb)); end
    tests++; if (err_cnt - eb !== 1 || done_cnt - db !== 0) begin
      fails++; $display("FAIL urun_pulses got err=%0d done=%0d want 1 0", err_cnt - eb, done_cnt - db);
    end
    tests++; if (err_cyc !== f) begin fails++; $display("FAIL urun_err_align got cycle %0d want %0d", err_cyc, f); end
    tx_bytes.delete(); tx_last_q.delete(); add_frame(60, 8'h05, 3);
    cb2 = cap.size();
    fork
      drive(-1);
      wait_fall(fb + 2, ok2);
    join
    set_exp(60, 8'h05, 3, 60);
    r2 = (rise_q.size() > rb + 1) ? rise_q[rb+1] : -10000;
    tests++; if (ok2 !== 1'b1 || r2 - f < 49) begin
      fails++; $display("FAIL urun_gap got %0d want >=49", r2 - f);
    end
    tests++; if (wire_fcs(cb2, 60) !== model_fcs()) begin
      fails++; $display("FAIL urun_next_fcs got %08h want %08h", wire_fcs(cb2, 60), model_fcs());
    end
    repeat (60) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int cb, rb, fb, db, eb, r1, f1, r2, f2;
    bit ok;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete();
    add_frame(60, 8'h40, 1);
    add_frame(60, 8'hC3, 5);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size(); db = done_cnt; eb = err_cnt;
    fork
      drive(-1);
      wait_fall(fb + 2, ok);
    join
    r1 = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f1 = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    r2 = (rise_q.size() > rb + 1) ? rise_q[rb+1] : -10000;
    f2 = (fall_q.size() > fb + 1) ? fall_q[fb+1] : 10000;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_timeout got fewer than 2 frames want 2"); end
    tests++; if (r2 - f1 !== 49) begin fails++; $display("FAIL b2b_gap got %0d want 49", r2 - f1); end
    tests++; if (f1 - r1 !== 288 || f2 - r2 !== 288) begin
      fails++; $display("FAIL b2b_txen_len got %0d,%0d want 288,288", f1 - r1, f2 - r2);
    end
    set_exp(60, 8'h40, 1, 60);
    tests++; if (wire_fcs(cb, 60) !== model_fcs() || data_bad(cb) !== 0) begin
      fails++; $display("FAIL b2b_frame1 got fcs %08h want %08h", wire_fcs(cb, 60), model_fcs());
    end
    set_exp(60, 8'hC3, 5, 60);
    tests++; if (wire_fcs(cb + 288, 60) !== model_fcs() || pre_bad(cb + 288) !== 0) begin
      fails++; $display("FAIL b2b_frame2 got fcs %08h want %08h", wire_fcs(cb + 288, 60), model_fcs());
    end
    tests++; if (done_cnt - db !== 2 || err_cnt - eb !== 0) begin
      fails++; $display("FAIL b2b_pulses got done=%0d err=%0d want 2 0", done_cnt - db, err_cnt - eb);
    end
    repeat (60) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int cb, rb, fb, r, f;
    bit ok, reached;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(60, 8'h21, 1);
    cb = cap.size();
    fork
      drive(-1);
      begin
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
          @(negedge clk);
          if (cap.size() >= cb + 32 + 4 * 5 + 2) begin
            reached = 1'b1;
            break;
          end
        end
        abort = 1'b1;
        s_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (reached !== 1'b1) begin fails++; $display("FAIL rmid_timeout got no byte 5 want byte 5"); end
        tests++; if (mon_txen !== 1'b0 || mon_busy !== 1'b0 || rdy !== 1'b0) begin
          fails++; $display("FAIL rmid_state got txen=%0b busy=%0b ready=%0b want 0 0 0", mon_txen, mon_busy, rdy);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
      end
    join
    abort = 1'b0;
    @(posedge clk); #1;
    tx_bytes.delete(); tx_last_q.delete(); add_frame(60, 8'h77, 1);
    cb = cap.size(); rb = rise_q.size(); fb = fall_q.size();
    fork
      drive(-1);
      wait_fall(fb + 1, ok);
    join
    set_exp(60, 8'h77, 1, 60);
    r = (rise_q.size() > rb) ? rise_q[rb] : -10000;
    f = (fall_q.size() > fb) ? fall_q[fb] : 10000;
    tests++; if (ok !== 1'b1 || f - r !== 288) begin fails++; $display("FAIL rmid_next_len got %0d want 288", f - r); end
    tests++; if (pre_bad(cb) !== 0) begin fails++; $display("FAIL rmid_next_preamble got %0d bad want 0", pre_bad(cb)); end
    tests++; if (wire_fcs(cb, 60) !== model_fcs() || data_bad(cb) !== 0) begin
      fails++; $display("FAIL rmid_next_fcs got %08h want %08h", wire_fcs(cb, 60), model_fcs());
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_padding();
    test_fcs_kat();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
